unidade_controle_mc: RTL and testbench
======================================

# unidade_controle_mc

Multicycle control unit for the RV64I-subset processor. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath enable and mux select, and publishes its state on `state_out` for the simulation monitor. It sits directly upstream of the datapath in `principal` and consumes the IR fields plus the ALU `zero`/`menor` flags.

## Interface
- `MEM_WAIT`, default 0: extra wait cycles per memory access (0..15).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `ir` input 32: current instruction register contents.
- `zero` input 1: ALU result == 0 (combinational from datapath).
- `menor` input 1: ALU signed less-than (combinational).
- `pc_write`, `ir_write`, `mem_write`, `mdr_write`, `alu_out_write`, `reg_write` output 1: register/memory enables.
- `alu_src_a` output 2: 00 PC, 01 regA, 10 oldPC.
- `alu_src_b` output 2: 00 regB, 01 const 4, 10 imm, 11 imm<<1.
- `alu_op` output 3: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `mem_to_reg` output 2: 00 ALUOut, 01 MDR, 10 PC, 11 imm.
- `pc_src` output 2: 00 ALU, 01 ALUOut, 10 ALU & ~1.
- `state_out` output 5: registered state code.
- `halted` output 1: high in HALT.

## Operation
- State codes: RESET 0, FETCH 1, DECODE 2, R_EXEC 3, I_EXEC 4, ALU_WB 5, ADDR 6, LOAD_MEM 7, LOAD_WB 8, STORE_MEM 9, BRANCH 10, LUI 11, JAL 12, JALR 13, HALT 14. Codes 15–31 are unreachable; if decoded, go to HALT.
- Unlisted outputs are 0 in each state.
- RESET: all outputs 0. Go to FETCH.
- FETCH: wait counter runs 0..MEM_WAIT. On the last count, assert `ir_write` and `pc_write` with src_a 00, src_b 01, add, pc_src 00. Then go to DECODE.
- DECODE: src_a 10, src_b 11, add, `alu_out_write` (branch/jump target). Dispatch on `ir[6:0]`:
  - 0110011 → R_EXEC
  - 0010011 → I_EXEC
  - 0000011 or 0100011 → ADDR
  - 1100011 → BRANCH
  - 0110111 → LUI
  - 1101111 → JAL
  - 1100111 → JALR
  - else → HALT
- R_EXEC: src_a 01, src_b 00, `alu_out_write`.
  - funct3 000 with funct7 0000000 → add; with funct7 0100000 → sub.
  - funct3 111 → and; 110 → or; 010 → slt. funct7 must be 0 for these.
  - Any other combination → HALT with no enables.
  - Legal → ALU_WB.
- I_EXEC: src_a 01, src_b 10, `alu_out_write`. funct3 000 → add, 010 → slt, 111 → and; else HALT. Legal → ALU_WB.
- ALU_WB: `reg_write`, mem_to_reg 00. Go to FETCH.
- ADDR: src_a 01, src_b 10, add, `alu_out_write`. funct3 must be 011, else HALT. Load → LOAD_MEM, store → STORE_MEM.
- LOAD_MEM: counter 0..MEM_WAIT. `mdr_write` on the last count, then LOAD_WB.
- LOAD_WB: `reg_write`, mem_to_reg 01. Go to FETCH.
- STORE_MEM: `mem_write` held for MEM_WAIT+1 cycles. Go to FETCH.
- BRANCH: src_a 01, src_b 00, sub. Taken condition by funct3:
  - 000 `zero`; 001 `!zero`; 100 `menor`; 101 `!menor`.
  - Other funct3 → HALT with no enables.
  - If taken: `pc_write`, pc_src 01. Then go to FETCH.
- LUI: `reg_write`, mem_to_reg 11. Go to FETCH.
- JAL: `reg_write`, mem_to_reg 10; `pc_write`, pc_src 01. Go to FETCH.
- JALR: `reg_write`, mem_to_reg 10; src_a 01, src_b 10, add; `pc_write`, pc_src 10. Go to FETCH.
- HALT: all enables 0, `halted`=1. Held until `reset` is asserted.

## Timing
- State and counter update on rising `clk`.
- `reset` low: asynchronously forces state RESET and counter 0. All outputs read 0 within the same cycle.
- `reset` released: the first edge moves RESET→FETCH.
- Outputs are decoded from the registered state, `ir` and counter. Exception: BRANCH `pc_write` also depends on `zero`/`menor` in the same cycle.
- Counter clears on every state change.
- Per-instruction cycles, with W = MEM_WAIT+1:
  - R/I type: W+3
  - Load: 2W+3
  - Store: 2W+2
  - Branch, LUI, JAL, JALR: W+2
- Reset asserted mid-instruction: the instruction is abandoned with no further enables. Writes already committed stay.
- `ir_write` and `pc_write` fire in the same FETCH cycle. DECODE therefore sees the new `ir` and uses oldPC for the target.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release → all outputs 0 and `state_out`=0 while low. `state_out`=1 one edge after release.
- Add, MEM_WAIT=0, `ir`=0x003100B3 → `state_out` sequence 1,2,3,5,1. `alu_op`=000 in R_EXEC; `reg_write`=1 only in state 5.
- Load, MEM_WAIT=2, `ir`=0x0000B083 (ld) → FETCH lasts 3 cycles, then 2,6. LOAD_MEM lasts 3 cycles with `mdr_write` only in its third cycle; then 8,1. Total 9 cycles.
- Branch, `ir`=0x00208463 (beq):
  - `zero`=1 in BRANCH → `pc_write`=1, `pc_src`=01.
  - Repeat with `zero`=0 → `pc_write`=0. Next state 1 in both cases.
- Illegal encodings → `state_out`=14, `halted`=1, all enables 0, held 20 cycles until reset:
  - opcode 0x7F
  - R-type with funct7 0x01
- Reset mid-store (MEM_WAIT=3, reset asserted on 2nd STORE_MEM cycle) → `mem_write` drops asynchronously; `state_out`=0.

Source files
------------

// File: rtl/unidade_controle_mc_if.sv
// Control bus between the multicycle control unit and the datapath.
interface unidade_controle_mc_if;
    logic [31:0] ir;
    logic        zero;
    logic        menor;
    logic        pc_write;
    logic        ir_write;
    logic        mem_write;
    logic        mdr_write;
    logic        alu_out_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  mem_to_reg;
    logic [1:0]  pc_src;
    logic [4:0]  state_out;
    logic        halted;

    // Control unit side: consumes IR fields and ALU flags, drives the datapath controls
    modport master (
        input  ir, zero, menor,
        output pc_write, ir_write, mem_write, mdr_write, alu_out_write, reg_write,
        output alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_src, state_out, halted
    );

    // Datapath side
    modport slave (
        output ir, zero, menor,
        input  pc_write, ir_write, mem_write, mdr_write, alu_out_write, reg_write,
        input  alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_src, state_out, halted
    );
endinterface

// File: rtl/unidade_controle_mc.sv
// Multicycle control unit for the RV64I-subset processor: fetch, decode,
// execute, memory and writeback sequencing with a configurable memory wait.
module unidade_controle_mc #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    unidade_controle_mc_if.master        bus
);
    localparam int unsigned ST_W  = 5;
    localparam int unsigned CNT_W = 4;

    localparam logic [ST_W-1:0] ST_RESET     = 5'd0;
    localparam logic [ST_W-1:0] ST_FETCH     = 5'd1;
    localparam logic [ST_W-1:0] ST_DECODE    = 5'd2;
    localparam logic [ST_W-1:0] ST_R_EXEC    = 5'd3;
    localparam logic [ST_W-1:0] ST_I_EXEC    = 5'd4;
    localparam logic [ST_W-1:0] ST_ALU_WB    = 5'd5;
    localparam logic [ST_W-1:0] ST_ADDR      = 5'd6;
    localparam logic [ST_W-1:0] ST_LOAD_MEM  = 5'd7;
    localparam logic [ST_W-1:0] ST_LOAD_WB   = 5'd8;
    localparam logic [ST_W-1:0] ST_STORE_MEM = 5'd9;
    localparam logic [ST_W-1:0] ST_BRANCH    = 5'd10;
    localparam logic [ST_W-1:0] ST_LUI       = 5'd11;
    localparam logic [ST_W-1:0] ST_JAL       = 5'd12;
    localparam logic [ST_W-1:0] ST_JALR      = 5'd13;
    localparam logic [ST_W-1:0] ST_HALT      = 5'd14;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             lastCnt;
    logic             countEn;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [14:0] unusedIrBits;

    logic       pcWrite, irWrite, memWrite, mdrWrite, aluOutWrite, regWrite, halted;
    logic [1:0] aluSrcA, aluSrcB, memToReg, pcSrc;
    logic [2:0] aluOp;
    logic       legal;
    logic       taken;

    assign opcode       = bus.ir[6:0];
    assign funct3       = bus.ir[14:12];
    assign funct7       = bus.ir[31:25];
    assign unusedIrBits = {bus.ir[24:15], bus.ir[11:7]};

    assign lastCnt = (waitCnt == CNT_W'(MEM_WAIT));
    assign countEn = (state == ST_FETCH) || (state == ST_LOAD_MEM) || (state == ST_STORE_MEM);

    // State register and memory wait counter; counter clears on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RESET;
            waitCnt <= '0;
        end else begin
            state <= nextState;
            if (nextState != state) begin
                waitCnt <= '0;
            end else if (countEn) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode from registered state, IR, counter and ALU flags
    always_comb begin
        nextState   = state;
        pcWrite     = 1'b0;
        irWrite     = 1'b0;
        memWrite    = 1'b0;
        mdrWrite    = 1'b0;
        aluOutWrite = 1'b0;
        regWrite    = 1'b0;
        halted      = 1'b0;
        aluSrcA     = 2'b00;
        aluSrcB     = 2'b00;
        memToReg    = 2'b00;
        pcSrc       = 2'b00;
        aluOp       = ALU_ADD;
        legal       = 1'b1;
        taken       = 1'b0;

        case (state)
            ST_RESET: nextState = ST_FETCH;

            ST_FETCH: begin
                if (lastCnt) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    aluSrcB   = 2'b01;
                    nextState = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Branch/jump target from oldPC while the new IR is decoded
                aluSrcA     = 2'b10;
                aluSrcB     = 2'b11;
                aluOutWrite = 1'b1;
                case (opcode)
                    OP_R:               nextState = ST_R_EXEC;
                    OP_I:               nextState = ST_I_EXEC;
                    OP_LOAD, OP_STORE:  nextState = ST_ADDR;
                    OP_BRANCH:          nextState = ST_BRANCH;
                    OP_LUI:             nextState = ST_LUI;
                    OP_JAL:             nextState = ST_JAL;
                    OP_JALR:            nextState = ST_JALR;
                    default:            nextState = ST_HALT;
                endcase
            end

            ST_R_EXEC: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: aluOp = ALU_ADD;
                    {7'b0100000, 3'b000}: aluOp = ALU_SUB;
                    {7'b0000000, 3'b111}: aluOp = ALU_AND;
                    {7'b0000000, 3'b110}: aluOp = ALU_OR;
                    {7'b0000000, 3'b010}: aluOp = ALU_SLT;
                    default:              legal = 1'b0;
                endcase
                if (legal) begin
                    aluSrcA     = 2'b01;
                    aluOutWrite = 1'b1;
                    nextState   = ST_ALU_WB;
                end else begin
                    aluOp     = ALU_ADD;
                    nextState = ST_HALT;
                end
            end

            ST_I_EXEC: begin
                case (funct3)
                    3'b000:  aluOp = ALU_ADD;
                    3'b010:  aluOp = ALU_SLT;
                    3'b111:  aluOp = ALU_AND;
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    aluSrcA     = 2'b01;
                    aluSrcB     = 2'b10;
                    aluOutWrite = 1'b1;
                    nextState   = ST_ALU_WB;
                end else begin
                    aluOp     = ALU_ADD;
                    nextState = ST_HALT;
                end
            end

            ST_ALU_WB: begin
                regWrite  = 1'b1;
                nextState = ST_FETCH;
            end

            ST_ADDR: begin
                if (funct3 == 3'b011 && (opcode == OP_LOAD || opcode == OP_STORE)) begin
                    aluSrcA     = 2'b01;
                    aluSrcB     = 2'b10;
                    aluOutWrite = 1'b1;
                    nextState   = (opcode == OP_LOAD) ? ST_LOAD_MEM : ST_STORE_MEM;
                end else begin
                    nextState = ST_HALT;
                end
            end

            ST_LOAD_MEM: begin
                if (lastCnt) begin
                    mdrWrite  = 1'b1;
                    nextState = ST_LOAD_WB;
                end
            end

            ST_LOAD_WB: begin
                regWrite  = 1'b1;
                memToReg  = 2'b01;
                nextState = ST_FETCH;
            end

            ST_STORE_MEM: begin
                memWrite = 1'b1;
                if (lastCnt) begin
                    nextState = ST_FETCH;
                end
            end

            ST_BRANCH: begin
                case (funct3)
                    3'b000:  taken = bus.zero;
                    3'b001:  taken = !bus.zero;
                    3'b100:  taken = bus.menor;
                    3'b101:  taken = !bus.menor;
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    aluSrcA   = 2'b01;
                    aluOp     = ALU_SUB;
                    nextState = ST_FETCH;
                    if (taken) begin
                        pcWrite = 1'b1;
                        pcSrc   = 2'b01;
                    end
                end else begin
                    nextState = ST_HALT;
                end
            end

            ST_LUI: begin
                regWrite  = 1'b1;
                memToReg  = 2'b11;
                nextState = ST_FETCH;
            end

            ST_JAL: begin
                regWrite  = 1'b1;
                memToReg  = 2'b10;
                pcWrite   = 1'b1;
                pcSrc     = 2'b01;
                nextState = ST_FETCH;
            end

            ST_JALR: begin
                regWrite  = 1'b1;
                memToReg  = 2'b10;
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b10;
                pcWrite   = 1'b1;
                pcSrc     = 2'b10;
                nextState = ST_FETCH;
            end

            ST_HALT: halted = 1'b1;

            default: nextState = ST_HALT;
        endcase
    end

    assign bus.pc_write      = pcWrite;
    assign bus.ir_write      = irWrite;
    assign bus.mem_write     = memWrite;
    assign bus.mdr_write     = mdrWrite;
    assign bus.alu_out_write = aluOutWrite;
    assign bus.reg_write     = regWrite;
    assign bus.alu_src_a     = aluSrcA;
    assign bus.alu_src_b     = aluSrcB;
    assign bus.alu_op        = aluOp;
    assign bus.mem_to_reg    = memToReg;
    assign bus.pc_src        = pcSrc;
    assign bus.state_out     = state;
    assign bus.halted        = halted;
endmodule

// File: tb/tb_unidade_controle_mc.sv
// Self-checking bench for unidade_controle_mc: table of instruction traces
// on a zero-wait unit plus hand sequences for wait states, halt and reset.
module tb_unidade_controle_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        zero = 1'b0;
    logic        menor = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          sel = 0;

    unidade_controle_mc_if bus0 ();
    unidade_controle_mc_if bus2 ();
    unidade_controle_mc_if bus3 ();

    unidade_controle_mc #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    unidade_controle_mc #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    unidade_controle_mc #(.MEM_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    assign bus0.ir = ir;  assign bus0.zero = zero;  assign bus0.menor = menor;
    assign bus2.ir = ir;  assign bus2.zero = zero;  assign bus2.menor = menor;
    assign bus3.ir = ir;  assign bus3.zero = zero;  assign bus3.menor = menor;

    // Control word: {pcw, irw, memw, mdrw, aluOutW, regW, srcA, srcB, op, memToReg, pcSrc, halted}
    logic [17:0] cwA [3];
    logic [4:0]  stA [3];
    assign cwA[0] = {bus0.pc_write, bus0.ir_write, bus0.mem_write, bus0.mdr_write, bus0.alu_out_write,
                     bus0.reg_write, bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.mem_to_reg,
                     bus0.pc_src, bus0.halted};
    assign cwA[1] = {bus2.pc_write, bus2.ir_write, bus2.mem_write, bus2.mdr_write, bus2.alu_out_write,
                     bus2.reg_write, bus2.alu_src_a, bus2.alu_src_b, bus2.alu_op, bus2.mem_to_reg,
                     bus2.pc_src, bus2.halted};
    assign cwA[2] = {bus3.pc_write, bus3.ir_write, bus3.mem_write, bus3.mdr_write, bus3.alu_out_write,
                     bus3.reg_write, bus3.alu_src_a, bus3.alu_src_b, bus3.alu_op, bus3.mem_to_reg,
                     bus3.pc_src, bus3.halted};
    assign stA[0] = bus0.state_out;
    assign stA[1] = bus2.state_out;
    assign stA[2] = bus3.state_out;

    always #5 clk = ~clk;

    localparam logic [17:0] CW_NONE  = 18'd0;
    localparam logic [17:0] CW_HALT  = 18'd1;
    localparam logic [17:0] CW_FETCH = {6'b110000, 2'b00, 2'b01, 3'b000, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_DEC   = {6'b000010, 2'b10, 2'b11, 3'b000, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_RADD  = {6'b000010, 2'b01, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_RSUB  = {6'b000010, 2'b01, 2'b00, 3'b001, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_RAND  = {6'b000010, 2'b01, 2'b00, 3'b010, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_ROR   = {6'b000010, 2'b01, 2'b00, 3'b011, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_RSLT  = {6'b000010, 2'b01, 2'b00, 3'b100, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_IADD  = {6'b000010, 2'b01, 2'b10, 3'b000, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_ISLT  = {6'b000010, 2'b01, 2'b10, 3'b100, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_WB    = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_LUI   = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b11, 2'b00, 1'b0};
    localparam logic [17:0] CW_JAL   = {6'b100001, 2'b00, 2'b00, 3'b000, 2'b10, 2'b01, 1'b0};
    localparam logic [17:0] CW_JALR  = {6'b100001, 2'b01, 2'b10, 3'b000, 2'b10, 2'b10, 1'b0};
    localparam logic [17:0] CW_BT    = {6'b100000, 2'b01, 2'b00, 3'b001, 2'b00, 2'b01, 1'b0};
    localparam logic [17:0] CW_BN    = {6'b000000, 2'b01, 2'b00, 3'b001, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_MDR   = {6'b000100, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] CW_LWB   = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 1'b0};
    localparam logic [17:0] CW_MEMW  = {6'b001000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] MASK_ALL = 18'h3FFFF;
    localparam logic [17:0] MASK_EN  = 18'h3F000;

    typedef struct {
        string            name;
        logic [31:0]      ir;
        logic             zero;
        logic             menor;
        int               len;
        logic [5:0][4:0]  seq;
        int               chk;
        logic [17:0]      cw;
        logic [17:0]      mask;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input string n, input logic [31:0] i, input logic z, input logic m,
                                   input int len, input int s0, input int s1, input int s2,
                                   input int s3, input int s4, input int s5, input int chk,
                                   input logic [17:0] cw, input logic [17:0] mask);
        vec_t v;
        v.name = n;  v.ir = i;  v.zero = z;  v.menor = m;  v.len = len;
        v.seq[0] = 5'(s0);  v.seq[1] = 5'(s1);  v.seq[2] = 5'(s2);
        v.seq[3] = 5'(s3);  v.seq[4] = 5'(s4);  v.seq[5] = 5'(s5);
        v.chk = chk;  v.cw = cw;  v.mask = mask;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Hold reset low for three edges, check the idle outputs, release and expect FETCH
    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstState", 32'(stA[sel]), 32'd0);
        check("rstOutputs", 32'(cwA[sel]), 32'(CW_NONE));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("releaseFetch", 32'(stA[sel]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        addVec("addFetch", 32'h003100B3, 1'b0, 1'b0, 5, 1, 2, 3, 5, 1, 0, 0, CW_FETCH, MASK_ALL);
        addVec("addDecode", 32'h003100B3, 1'b0, 1'b0, 5, 1, 2, 3, 5, 1, 0, 1, CW_DEC, MASK_ALL);
        addVec("addExec", 32'h003100B3, 1'b0, 1'b0, 5, 1, 2, 3, 5, 1, 0, 2, CW_RADD, MASK_ALL);
        addVec("addWb", 32'h003100B3, 1'b0, 1'b0, 5, 1, 2, 3, 5, 1, 0, 3, CW_WB, MASK_ALL);
        addVec("sub", 32'h403100B3, 1'b0, 1'b0, 5, 1, 2, 3, 5, 1, 0, 2, CW_RSUB, MASK_ALL);
        addVec("and", 32'h003170B3, 1'b0, 1'b0, 5, 1, 2, 3, 5, 1, 0, 2, CW_RAND, MASK_ALL);
        addVec("or", 32'h003160B3, 1'b0, 1'b0, 5, 1, 2, 3, 5, 1, 0, 2, CW_ROR, MASK_ALL);
        addVec("slt", 32'h003120B3, 1'b0, 1'b0, 5, 1, 2, 3, 5, 1, 0, 2, CW_RSLT, MASK_ALL);
        addVec("addi", 32'h00510093, 1'b0, 1'b0, 5, 1, 2, 4, 5, 1, 0, 2, CW_IADD, MASK_ALL);
        addVec("slti", 32'h00512093, 1'b0, 1'b0, 5, 1, 2, 4, 5, 1, 0, 2, CW_ISLT, MASK_ALL);
        addVec("lui", 32'h123450B7, 1'b0, 1'b0, 4, 1, 2, 11, 1, 0, 0, 2, CW_LUI, MASK_ALL);
        addVec("jal", 32'h008000EF, 1'b0, 1'b0, 4, 1, 2, 12, 1, 0, 0, 2, CW_JAL, MASK_ALL);
        addVec("jalr", 32'h000080E7, 1'b0, 1'b0, 4, 1, 2, 13, 1, 0, 0, 2, CW_JALR, MASK_ALL);
        addVec("beqTaken", 32'h00208463, 1'b1, 1'b0, 4, 1, 2, 10, 1, 0, 0, 2, CW_BT, MASK_ALL);
        addVec("beqNot", 32'h00208463, 1'b0, 1'b0, 4, 1, 2, 10, 1, 0, 0, 2, CW_BN, MASK_ALL);
        addVec("bneTaken", 32'h00209463, 1'b0, 1'b0, 4, 1, 2, 10, 1, 0, 0, 2, CW_BT, MASK_ALL);
        addVec("bltTaken", 32'h0020C463, 1'b0, 1'b1, 4, 1, 2, 10, 1, 0, 0, 2, CW_BT, MASK_ALL);
        addVec("bgeNot", 32'h0020D463, 1'b0, 1'b1, 4, 1, 2, 10, 1, 0, 0, 2, CW_BN, MASK_ALL);
        addVec("ldAddr", 32'h0000B083, 1'b0, 1'b0, 6, 1, 2, 6, 7, 8, 1, 2, CW_IADD, MASK_ALL);
        addVec("ldMem", 32'h0000B083, 1'b0, 1'b0, 6, 1, 2, 6, 7, 8, 1, 3, CW_MDR, MASK_ALL);
        addVec("ldWb", 32'h0000B083, 1'b0, 1'b0, 6, 1, 2, 6, 7, 8, 1, 4, CW_LWB, MASK_ALL);
        addVec("sdMem", 32'h0010B023, 1'b0, 1'b0, 5, 1, 2, 6, 9, 1, 0, 3, CW_MEMW, MASK_ALL);
        addVec("lwIllegal", 32'h0000A083, 1'b0, 1'b0, 4, 1, 2, 6, 14, 0, 0, 3, CW_HALT, MASK_ALL);
        addVec("rFunct7Bad", 32'h023100B3, 1'b0, 1'b0, 4, 1, 2, 3, 14, 0, 0, 2, CW_NONE, MASK_EN);
        addVec("brFunct3Bad", 32'h0020A463, 1'b1, 1'b0, 4, 1, 2, 10, 14, 0, 0, 2, CW_NONE, MASK_EN);
        addVec("opcode7F", 32'h0000007F, 1'b0, 1'b0, 3, 1, 2, 14, 0, 0, 0, 2, CW_HALT, MASK_ALL);

        // Table of zero-wait instruction traces
        sel = 0;
        foreach (vecs[n]) begin
            ir    = vecs[n].ir;
            zero  = vecs[n].zero;
            menor = vecs[n].menor;
            doReset();
            for (int k = 0; k < vecs[n].len; k++) begin
                @(negedge clk);
                check($sformatf("%s.st%0d", vecs[n].name, k), 32'(stA[sel]), 32'(vecs[n].seq[k]));
                if (k == vecs[n].chk) begin
                    check($sformatf("%s.cw", vecs[n].name), 32'(cwA[sel] & vecs[n].mask),
                          32'(vecs[n].cw & vecs[n].mask));
                end
            end
        end
        zero  = 1'b0;
        menor = 1'b0;

        // Branch flag sampled in the same BRANCH cycle
        sel = 0;
        ir  = 32'h00208463;
        doReset();
        repeat (3) @(negedge clk);
        check("brLateState", 32'(stA[sel]), 32'd10);
        check("brLateZero0", 32'(cwA[sel][17]), 32'd0);
        zero = 1'b1;
        #1;
        check("brLateZero1", 32'(cwA[sel][17]), 32'd1);
        check("brLatePcSrc", 32'(cwA[sel][2:1]), 32'd1);
        @(posedge clk);
        #1;
        check("brLateNext", 32'(stA[sel]), 32'd1);
        zero = 1'b0;

        // Load with two wait cycles: 3-cycle FETCH and LOAD_MEM, 9 cycles total
        sel = 1;
        ir  = 32'h0000B083;
        doReset();
        for (int k = 0; k < 10; k++) begin
            logic [4:0] expSt;
            @(negedge clk);
            if (k < 3)      expSt = 5'd1;
            else if (k == 3) expSt = 5'd2;
            else if (k == 4) expSt = 5'd6;
            else if (k < 8)  expSt = 5'd7;
            else if (k == 8) expSt = 5'd8;
            else             expSt = 5'd1;
            check($sformatf("ldW2.st%0d", k), 32'(stA[sel]), 32'(expSt));
            check($sformatf("ldW2.irw%0d", k), 32'(cwA[sel][16]), (k == 2) ? 32'd1 : 32'd0);
            check($sformatf("ldW2.mdr%0d", k), 32'(cwA[sel][14]), (k == 7) ? 32'd1 : 32'd0);
        end

        // Full store with three wait cycles: mem_write held four cycles, 10 cycles total
        sel = 2;
        ir  = 32'h0010B023;
        doReset();
        for (int k = 0; k < 11; k++) begin
            logic [4:0] expSt;
            @(negedge clk);
            if (k < 4)       expSt = 5'd1;
            else if (k == 4) expSt = 5'd2;
            else if (k == 5) expSt = 5'd6;
            else if (k < 10) expSt = 5'd9;
            else             expSt = 5'd1;
            check($sformatf("sdW3.st%0d", k), 32'(stA[sel]), 32'(expSt));
            check($sformatf("sdW3.memw%0d", k), 32'(cwA[sel][15]), (k >= 6 && k < 10) ? 32'd1 : 32'd0);
        end

        // Reset asserted in the second STORE_MEM cycle drops mem_write at once
        doReset();
        repeat (8) @(negedge clk);
        check("midStoreState", 32'(stA[sel]), 32'd9);
        check("midStoreMemw", 32'(cwA[sel][15]), 32'd1);
        reset = 1'b0;
        #1;
        check("midRstMemw", 32'(cwA[sel][15]), 32'd0);
        check("midRstState", 32'(stA[sel]), 32'd0);
        check("midRstOutputs", 32'(cwA[sel]), 32'(CW_NONE));
        @(negedge clk);
        reset = 1'b1;

        // Illegal encodings park in HALT until reset
        sel = 0;
        for (int t = 0; t < 2; t++) begin
            int waitCycles;
            ir = (t == 0) ? 32'h0000007F : 32'h023100B3;
            doReset();
            waitCycles = 0;
            while (stA[sel] != 5'd14 && waitCycles < 8) begin
                @(negedge clk);
                waitCycles++;
            end
            check($sformatf("haltReached%0d", t), 32'(stA[sel]), 32'd14);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                check($sformatf("haltHold%0d.st%0d", t, c), 32'(stA[sel]), 32'd14);
                check($sformatf("haltHold%0d.cw%0d", t, c), 32'(cwA[sel]), 32'(CW_HALT));
            end
            reset = 1'b0;
            #1;
            check($sformatf("haltExit%0d", t), 32'(stA[sel]), 32'd0);
            @(negedge clk);
            reset = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
